// File: rtl/ks_pipe_subtractor.sv
// Three-stage Kogge-Stone subtractor D = A - B - Bin with valid/ready flow control.
// Define KS_SUB_OVF_EN to add the registered signed-overflow output ovf.
module ks_pipe_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
`ifdef KS_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             Bout
);

  localparam int L  = $clog2(WIDTH);
  localparam int L1 = (L + 1) / 2;

  // Group-generate after prefix levels [lo, hi); span of level k is 2**k.
  function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g_in,
                                            input logic [WIDTH-1:0] p_in,
                                            input int lo, input int hi);
    logic [WIDTH-1:0] g, p, gn, pn;
    g = g_in;
    p = p_in;
    for (int k = lo; k < hi; k++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << k)) begin
          gn[i] = g[i] | (p[i] & g[i-(1<<k)]);
          pn[i] = p[i] & p[i-(1<<k)];
        end
      end
      g = gn;
      p = pn;
    end
    return g;
  endfunction

  function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p_in,
                                            input int lo, input int hi);
    logic [WIDTH-1:0] p, pn;
    p = p_in;
    for (int k = lo; k < hi; k++) begin
      pn = p;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << k)) pn[i] = p[i] & p[i-(1<<k)];
      end
      p = pn;
    end
    return p;
  endfunction

  logic             vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic             ld_p0, ld_p1, ld_p2;
  logic [WIDTH-1:0] g_p0_q, g_p0_d, p_p0_q, p_p0_d, hp_p0_q, hp_p0_d;
  logic             cin_p0_q, cin_p0_d, cin_p1_q, cin_p1_d;
  logic [WIDTH-1:0] g_p1_q, g_p1_d, hp_p1_q, hp_p1_d;
  logic [WIDTH-1:0] d_q, d_d, nb, g0, sum;
  logic             bout_q, bout_d;
`ifdef KS_SUB_OVF_EN
  logic             am_p0_q, am_p0_d, bm_p0_q, bm_p0_d;
  logic             am_p1_q, am_p1_d, bm_p1_q, bm_p1_d;
  logic             ovf_q, ovf_d;
`endif

  // A stage loads when empty or when its contents move on this cycle.
  always_comb begin
    ld_p2    = !vld_p2_q || out_ready;
    ld_p1    = !vld_p1_q || ld_p2;
    ld_p0    = !vld_p0_q || ld_p1;
    in_ready = ld_p0;
    vld_p0_d = ld_p0 ? in_valid : vld_p0_q;
    vld_p1_d = ld_p1 ? vld_p0_q : vld_p1_q;
    vld_p2_d = ld_p2 ? vld_p1_q : vld_p2_q;
  end

  // Stage 1: generate/propagate with borrow-in folded into bit 0, first prefix levels
  always_comb begin
    nb       = ~B;
    g0       = A & nb;
    g0[0]    = g0[0] | ((A[0] ^ nb[0]) & ~Bin);
    g_p0_d   = g_p0_q;
    p_p0_d   = p_p0_q;
    hp_p0_d  = hp_p0_q;
    cin_p0_d = cin_p0_q;
    if (ld_p0) begin
      g_p0_d   = ks_g(g0, A ^ nb, 0, L1);
      p_p0_d   = ks_p(A ^ nb, 0, L1);
      hp_p0_d  = A ^ nb;
      cin_p0_d = ~Bin;
    end
`ifdef KS_SUB_OVF_EN
    am_p0_d = ld_p0 ? A[WIDTH-1] : am_p0_q;
    bm_p0_d = ld_p0 ? B[WIDTH-1] : bm_p0_q;
`endif
  end

  // Stage 2: remaining prefix levels yield the carry out of every bit
  always_comb begin
    g_p1_d   = ld_p1 ? ks_g(g_p0_q, p_p0_q, L1, L) : g_p1_q;
    hp_p1_d  = ld_p1 ? hp_p0_q : hp_p1_q;
    cin_p1_d = ld_p1 ? cin_p0_q : cin_p1_q;
`ifdef KS_SUB_OVF_EN
    am_p1_d = ld_p1 ? am_p0_q : am_p1_q;
    bm_p1_d = ld_p1 ? bm_p0_q : bm_p1_q;
`endif
  end

  // Stage 3: sum XOR; outputs are forced to zero when the stage is empty
  always_comb begin
    sum    = hp_p1_q ^ {g_p1_q[WIDTH-2:0], cin_p1_q};
    d_d    = d_q;
    bout_d = bout_q;
    if (ld_p2) begin
      d_d    = vld_p1_q ? sum : '0;
      bout_d = vld_p1_q & ~g_p1_q[WIDTH-1];
    end
`ifdef KS_SUB_OVF_EN
    ovf_d = ovf_q;
    if (ld_p2) ovf_d = vld_p1_q & (am_p1_q != bm_p1_q) & (sum[WIDTH-1] != am_p1_q);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
`ifdef KS_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
`ifdef KS_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    g_p0_q   <= g_p0_d;
    p_p0_q   <= p_p0_d;
    hp_p0_q  <= hp_p0_d;
    cin_p0_q <= cin_p0_d;
    g_p1_q   <= g_p1_d;
    hp_p1_q  <= hp_p1_d;
    cin_p1_q <= cin_p1_d;
`ifdef KS_SUB_OVF_EN
    am_p0_q  <= am_p0_d;
    bm_p0_q  <= bm_p0_d;
    am_p1_q  <= am_p1_d;
    bm_p1_q  <= bm_p1_d;
`endif
  end

  assign out_valid = vld_p2_q;
  assign D         = d_q;
  assign Bout      = bout_q;
`ifdef KS_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ks_pipe_subtractor.sv
// Self-checking bench for ks_pipe_subtractor: directed vectors, stalls, reset
// and random streams checked against an arithmetic reference queue.
module tb_ks_pipe_subtractor;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, Bin, Bout;
  logic [W-1:0] A, B, D;
`ifdef KS_SUB_OVF_EN
  logic         ovf;
`endif

  ks_pipe_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D),
`ifdef KS_SUB_OVF_EN
    .ovf(ovf),
`endif
    .Bout(Bout));

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic         lat_chk = 1'b0;
  logic [W-1:0] q_d[$];
  logic         q_b[$];
  logic         q_o[$];
  int           q_c[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular subtraction; borrow from an unsigned compare.
  task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0]   diff;
    logic [W-1:0] d;
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    d    = diff[W-1:0];
    q_d.push_back(d);
    q_b.push_back(({1'b0, b} + {{W{1'b0}}, bi}) > {1'b0, a});
    q_o.push_back((a[W-1] != b[W-1]) && (d[W-1] != a[W-1]));
    q_c.push_back(cyc);
  endtask

  task automatic flush_model();
    q_d.delete(); q_b.delete(); q_o.delete(); q_c.delete();
  endtask

  // One clock cycle: drive, sample at the falling edge, score, advance.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bi, input logic ordy, output logic acc);
    in_valid = iv; A = a; B = b; Bin = bi; out_ready = ordy;
    @(negedge clk);
    if (out_valid) begin
      chk("out_has_pending_set", (q_d.size() > 0), 1);
      if (q_d.size() > 0) begin
        chk("D", D, q_d[0]);
        chk("Bout", Bout, q_b[0]);
`ifdef KS_SUB_OVF_EN
        chk("ovf", ovf, q_o[0]);
`endif
        if (out_ready) begin
          if (lat_chk) chk("latency", cyc - q_c[0], 3);
          void'(q_d.pop_front()); void'(q_b.pop_front());
          void'(q_o.pop_front()); void'(q_c.pop_front());
        end
      end
    end else begin
      chk("D_idle_zero", D, 0);
      chk("Bout_idle_zero", Bout, 0);
`ifdef KS_SUB_OVF_EN
      chk("ovf_idle_zero", ovf, 0);
`endif
    end
    acc = iv && in_ready;
    if (acc) model_push(a, b, bi);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 20 && q_d.size() > 0; c++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("drained", q_d.size(), 0);
  endtask

  logic [W-1:0] va[5], vb[5];
  logic         vbi[5];

  initial begin
    logic acc;
    int   idx, n_acc;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_D", D, 0);
    chk("rst_Bout", Bout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner vectors with exact latency
    lat_chk = 1'b1;
    step(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, acc); chk("acc_dir0", acc, 1);
    drain();
    step(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, acc);
    step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, acc);
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, acc);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, acc);
    step(1'b1, 16'h8000, 16'h0000, 1'b1, 1'b1, acc);
    step(1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, acc);
    drain();

    // Back-to-back throughput with the output always ready
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc);
      if (acc) n_acc++;
    end
    chk("throughput_accepts", n_acc, 8);
    drain();

    // Stall: five sets offered with out_ready low, then released
    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vbi[i] = 1'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 12 && idx < 5; c++) begin
      step(1'b1, va[idx], vb[idx], vbi[idx], (c >= 6), acc);
      if (acc) idx++;
      if (c == 5) begin
        chk("stall_accepted", idx, 3);
        chk("stall_in_ready", in_ready, 0);
      end
    end
    chk("stall_all_accepted", idx, 5);
    drain();

    // Stream 100 random sets with out_ready toggling every cycle
    idx = 0;
    for (int c = 0; c < 400 && idx < 100; c++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), (c % 2 == 0), acc);
      if (acc) idx++;
    end
    chk("toggle_stream_done", idx, 100);
    drain();

    // Random valid and ready on both sides
    idx = 0;
    for (int c = 0; c < 600 && idx < 100; c++) begin
      step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), acc);
      if (acc) idx++;
    end
    chk("random_stream_done", idx, 100);
    drain();

    // Reset between clock edges with two sets in flight
    lat_chk = 1'b1;
    step(1'b1, 16'h1234, 16'h0034, 1'b0, 1'b1, acc);
    step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    #2;
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_D", D, 0);
    chk("async_rst_Bout", Bout, 0);
    chk("async_rst_in_ready", in_ready, 1);
    flush_model();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int c = 0; c < 5; c++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b1, 16'h00F0, 16'h000F, 1'b1, 1'b1, acc);
    chk("post_rst_acc", acc, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
